// File: rtl/arbitro_mux4.sv
// Four-requester arbiter with registered one-hot grant and a 4:1 data mux on sel.
// Round-robin by default; define ARBITRO_PRIORIDAD_FIJA_EN for fixed lowest-index priority.
module arbitro_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [1:0] winner;
  logic       xfer;
  logic       withdraw;

  logic [WIDTH-1:0] d_arr [4];
  assign d_arr[0] = d0;
  assign d_arr[1] = d1;
  assign d_arr[2] = d2;
  assign d_arr[3] = d3;

  assign xfer     = (state_q == GRANT) && out_ready;
  assign withdraw = (state_q == GRANT) && !out_ready && !req[sel_q];

`ifdef ARBITRO_PRIORIDAD_FIJA_EN
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) w = 2'(i);
    end
    return w;
  endfunction

  always_comb begin
    winner = pick_fixed(req);
  end
`else
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (r[idx] && !found) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  logic [1:0] base;

  // On a transfer edge last is being replaced by sel, so search from the new value.
  always_comb begin
    base   = xfer ? sel_q : last_q;
    winner = pick_rr(req, base);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (xfer) last_d = sel_q;
    if ((state_q == IDLE) || xfer || withdraw) begin
      if (req != 4'b0000) begin
        state_d = GRANT;
        sel_d   = winner;
        gnt_d   = 4'b0001 << winner;
      end else begin
        // sel is kept so out_data keeps showing the last selected requester.
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    end
  end

  always_comb begin
    gnt       = gnt_q;
    sel       = sel_q;
    out_valid = (state_q == GRANT);
    out_data  = d_arr[sel_q];
  end

endmodule

// File: doc/arbitro_mux4.md
ARBITRO_MUX4 -- requirements
Module: arbitro_mux4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width of each requester port and of out_data.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4: req[i] is the request from requester i.
REQ-005 The block SHALL have ports d0, d1, d2, d3, input, WIDTH each: requester data.
REQ-006 The block SHALL have port gnt, output, 4: one-hot grant, registered.
REQ-007 The block SHALL have port sel, output, 2: index of the granted requester, registered; it drives the 4:1 data selection.
REQ-008 The block SHALL have port out_valid, output, 1: out_data is valid.
REQ-009 The block SHALL have port out_data, output, WIDTH: d[sel], combinational from registered sel.
REQ-010 The block SHALL have port out_ready, input, 1: the consumer accepts out_data this cycle.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (gnt=0, out_valid=0) and GRANT (gnt one-hot, out_valid=1).
REQ-012 In IDLE, the block SHALL register a winner, load gnt and sel, and enter GRANT at the next rising edge if req!=0; it SHALL otherwise stay in IDLE. Latency is 1 cycle from sampled req to out_valid.
REQ-013 Round-robin SHALL search from (last+1) mod 4 upward with wrap-around (3->0). Here last is the 2-bit index of the most recent completed transfer.
REQ-014 A transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1; last SHALL load sel on that edge.
REQ-015 On a transfer edge with req!=0, the block SHALL re-arbitrate on that same edge and stay in GRANT with the new winner: back-to-back, no idle cycle. The winner's own request ranks lowest because last has been updated.
REQ-016 On a transfer edge with req=0, the block SHALL return to IDLE.
REQ-017 One grant SHALL carry exactly one beat; a requester holding req high keeps competing.
REQ-018 In GRANT, if req[sel]=0 on an edge without a transfer, the block SHALL withdraw the grant with no transfer and leave last unchanged. It SHALL then re-arbitrate over the remaining requests as in REQ-015/REQ-016.
REQ-019 gnt, sel and out_valid SHALL stay stable while in GRANT until a transfer or a withdrawal.
REQ-020 out_data SHALL equal d[sel] in every cycle, including IDLE, where it shows the last registered sel.
REQ-021 gnt SHALL never have more than one bit set.

Reset
REQ-022 On rst_n low, the block SHALL asynchronously force state=IDLE, gnt=4'b0000, sel=2'b00, out_valid=0, last=2'b11, so requester 0 has first priority.
REQ-023 A reset asserted in GRANT SHALL drop the pending beat with no transfer; arbitration SHALL resume on the first rising edge after rst_n rises.

Configuration
REQ-024 Macro ARBITRO_PRIORIDAD_FIJA_EN: when defined, the winner SHALL always be the lowest-index asserted req and last SHALL be ignored.
REQ-025 When the macro is not defined, the block SHALL use round-robin per REQ-013.
REQ-026 Ports, latency and handshake SHALL be identical in both builds.

Verification
REQ-027 Reset, then req=4'b1111 with out_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles; out_data tracks d0..d3 (e.g. 8'hA0..8'hA3), no bubble.
REQ-028 req=4'b0100, out_ready=0 for 3 cycles then 1 -> gnt=4'b0100, sel=2 held 4 cycles; one transfer of d2; IDLE next if req=0.
REQ-029 After last=1, req=4'b0011 -> grant 0; after that transfer with req still 4'b0011 -> grant 1.
REQ-030 GRANT on requester 3 with out_ready=0, then req[3] drops while req[1]=1 -> next edge gnt=4'b0010; last unchanged; no transfer counted for requester 3.
REQ-031 rst_n pulsed low mid-GRANT -> gnt=0, out_valid=0 immediately, without a clock edge; req=4'b1000 after release -> grant 3 after 1 cycle.
REQ-032 ARBITRO_PRIORIDAD_FIJA_EN build, req=4'b1111 with out_ready=1 -> grant 0 every cycle; requesters 1-3 starve.
